// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// load/store path. Round-robin on conflict, one transaction at a time, with
// an optional ready timeout and a misaligned-data-access fast error path.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_valid_o,
  output logic              err_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;       // current / most recent owner
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;

  logic              d_req_s;
  logic              grant_data_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic              timeout_hit_s;

  assign d_req_s       = d_read_i | d_write_i;
  assign cnt_inc_s     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_inc_s == TIMEOUT_C);

  // Arbitration: a lone requester wins; on conflict the one that was not last owner wins.
  always_comb begin
    grant_data_s = 1'b0;
    if (d_req_s && if_req_i) begin
      grant_data_s = (owner_q == OWN_FETCH);
    end else begin
      grant_data_s = d_req_s;
    end
  end

  // Next-state and next-register logic of the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (if_req_i || d_req_s) begin
          if (grant_data_s) begin
            owner_d = OWN_DATA;
            if (d_addr_i[1:0] != 2'b00) begin
              // Misaligned data access: answer with an error, never touch memory.
              state_d   = ST_RESP;
              err_d     = 1'b1;
              d_valid_d = 1'b1;
              d_rdata_d = {DATA_W{1'b0}};
            end else begin
              state_d     = ST_XFER;
              mem_req_d   = 1'b1;
              mem_we_d    = d_write_i;
              mem_addr_d  = d_addr_i;
              mem_wdata_d = d_wdata_i;
            end
          end else begin
            owner_d    = OWN_FETCH;
            state_d    = ST_XFER;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (mem_ready_i) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (owner_q == OWN_DATA) begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else if (timeout_hit_s) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = cnt_inc_s;
          if (owner_q == OWN_DATA) begin
            d_valid_d = 1'b1;
            d_rdata_d = {DATA_W{1'b0}};
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = {DATA_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_RESP: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        cnt_d     = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      cnt_q       <= {CNT_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_valid_o   = d_valid_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_o     = (if_req_i & ~if_valid_q) | (d_req_s & ~d_valid_q);

endmodule
